// File: rtl/timer_nch.sv
// timer_nch: N-channel programmable timer/counter on the MIO bus.
// Each channel has its own prescaler, reload/count registers, three counting
// modes (one-shot, periodic, square), a sticky done flag and a timer output.
// The per-channel done flags, gated by IRQ_EN, are ORed into a registered irq.
module timer_nch #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 32,
    parameter int PRESC_W  = 8
) (
    input  logic                clk,
    input  logic                RSTN,
    input  logic                we,
    input  logic [5:0]          addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [CHANNELS-1:0] cnt_out,
    output logic                irq
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_RELOAD = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_SQUARE  = 2'b10;

    localparam logic [WIDTH-1:0]   COUNT_ONE = WIDTH'(1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    logic [3:0] sel_chan;
    logic [1:0] sel_reg;
    logic       wdata_unused;

    // Channel state
    logic [CHANNELS-1:0] en_q, en_d;
    logic [CHANNELS-1:0] irq_en_q, irq_en_d;
    logic [CHANNELS-1:0] done_q, done_d;
    logic [CHANNELS-1:0] cnt_out_q, cnt_out_d;
    logic [1:0]          mode_q      [CHANNELS];
    logic [1:0]          mode_d      [CHANNELS];
    logic [PRESC_W-1:0]  presc_q     [CHANNELS];
    logic [PRESC_W-1:0]  presc_d     [CHANNELS];
    logic [PRESC_W-1:0]  presc_cnt_q [CHANNELS];
    logic [PRESC_W-1:0]  presc_cnt_d [CHANNELS];
    logic [WIDTH-1:0]    reload_q    [CHANNELS];
    logic [WIDTH-1:0]    reload_d    [CHANNELS];
    logic [WIDTH-1:0]    count_q     [CHANNELS];
    logic [WIDTH-1:0]    count_d     [CHANNELS];
    logic                irq_q, irq_d;

    // Per-channel decoded strobes and events
    logic [CHANNELS-1:0] ctrl_wr;
    logic [CHANNELS-1:0] reload_wr;
    logic [CHANNELS-1:0] count_wr;
    logic [CHANNELS-1:0] status_wr;
    logic [CHANNELS-1:0] bus_load;
    logic [CHANNELS-1:0] en_rise;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] terminal;

    assign sel_chan = addr[5:2];
    assign sel_reg  = addr[1:0];

    // Bits of wdata above the used fields are intentionally ignored
    assign wdata_unused = ^wdata;

    // Decode bus writes per channel and derive tick/terminal events; channels
    // beyond CHANNELS never match, so out-of-range writes fall on the floor
    always_comb begin
        ctrl_wr   = '0;
        reload_wr = '0;
        count_wr  = '0;
        status_wr = '0;
        bus_load  = '0;
        en_rise   = '0;
        tick      = '0;
        terminal  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (we && (sel_chan == 4'(i))) begin
                ctrl_wr[i]   = (sel_reg == REG_CTRL);
                reload_wr[i] = (sel_reg == REG_RELOAD);
                count_wr[i]  = (sel_reg == REG_COUNT);
                status_wr[i] = (sel_reg == REG_STATUS);
            end
            bus_load[i] = reload_wr[i] | count_wr[i];
            en_rise[i]  = ctrl_wr[i] & wdata[0] & ~en_q[i];
            // >= keeps the prescaler from running past a newly lowered PRESC
            tick[i]     = en_q[i] && (presc_cnt_q[i] >= presc_q[i]);
            // A COUNT/RELOAD write in the same cycle suppresses the terminal event
            terminal[i] = tick[i] && (count_q[i] == COUNT_ONE) && !bus_load[i];
        end
    end

    // Next-state logic for every channel register
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            en_d[i]        = en_q[i];
            irq_en_d[i]    = irq_en_q[i];
            done_d[i]      = done_q[i];
            cnt_out_d[i]   = cnt_out_q[i];
            mode_d[i]      = mode_q[i];
            presc_d[i]     = presc_q[i];
            presc_cnt_d[i] = presc_cnt_q[i];
            reload_d[i]    = reload_q[i];
            count_d[i]     = count_q[i];

            // Prescaler: free-runs 0..PRESC while enabled, restarts on loads
            if (bus_load[i] || !en_q[i] || tick[i]) begin
                presc_cnt_d[i] = '0;
            end else begin
                presc_cnt_d[i] = presc_cnt_q[i] + PRESC_ONE;
            end

            // Control fields; a bus write wins over the one-shot auto-disable
            if (ctrl_wr[i]) begin
                en_d[i]     = wdata[0];
                mode_d[i]   = wdata[2:1];
                irq_en_d[i] = wdata[3];
                presc_d[i]  = wdata[8 +: PRESC_W];
            end else if (terminal[i] && (mode_q[i] == MODE_ONESHOT)) begin
                en_d[i] = 1'b0;
            end

            if (reload_wr[i]) begin
                reload_d[i] = wdata[WIDTH-1:0];
            end

            // Counter: bus loads first, then enable-reload, terminal, decrement
            if (bus_load[i]) begin
                count_d[i] = wdata[WIDTH-1:0];
            end else if (en_rise[i] && (count_q[i] == '0)) begin
                count_d[i] = reload_q[i];
            end else if (terminal[i]) begin
                count_d[i] = (mode_q[i] == MODE_ONESHOT) ? '0 : reload_q[i];
            end else if (tick[i] && (count_q[i] > COUNT_ONE)) begin
                count_d[i] = count_q[i] - COUNT_ONE;
            end

            // Timer output: one-shot holds high until restarted, periodic
            // pulses for one cycle, square toggles on each terminal event
            if (terminal[i]) begin
                cnt_out_d[i] = (mode_q[i] == MODE_SQUARE) ? ~cnt_out_q[i] : 1'b1;
            end else if (mode_q[i][0]) begin
                cnt_out_d[i] = 1'b0;
            end else if ((mode_q[i] == MODE_ONESHOT) && (bus_load[i] || en_rise[i])) begin
                cnt_out_d[i] = 1'b0;
            end

            // Sticky done: setting beats a simultaneous write-1-to-clear
            if (terminal[i]) begin
                done_d[i] = 1'b1;
            end else if (status_wr[i] && wdata[0]) begin
                done_d[i] = 1'b0;
            end
        end
        irq_d = |(done_q & irq_en_q);
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            en_q      <= '0;
            irq_en_q  <= '0;
            done_q    <= '0;
            cnt_out_q <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]      <= '0;
                presc_q[i]     <= '0;
                presc_cnt_q[i] <= '0;
                reload_q[i]    <= '0;
                count_q[i]     <= '0;
            end
        end else begin
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            cnt_out_q <= cnt_out_d;
            irq_q     <= irq_d;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]      <= mode_d[i];
                presc_q[i]     <= presc_d[i];
                presc_cnt_q[i] <= presc_cnt_d[i];
                reload_q[i]    <= reload_d[i];
                count_q[i]     <= count_d[i];
            end
        end
    end

    // Combinational read mux; unmatched channels read as zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_chan == 4'(i)) begin
                case (sel_reg)
                    REG_CTRL: begin
                        rdata[0]            = en_q[i];
                        rdata[2:1]          = mode_q[i];
                        rdata[3]            = irq_en_q[i];
                        rdata[8 +: PRESC_W] = presc_q[i];
                    end
                    REG_RELOAD: rdata[WIDTH-1:0] = reload_q[i];
                    REG_COUNT:  rdata[WIDTH-1:0] = count_q[i];
                    default: begin
                        rdata[0] = done_q[i];
                        rdata[1] = cnt_out_q[i];
                    end
                endcase
            end
        end
    end

    assign cnt_out = cnt_out_q;
    assign irq     = irq_q;

endmodule
